// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
// FSM states, requester owner encoding, wait-counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner select between CPU and debug port.
// Ports: cpu_req_i/dbg_req_i requests, last_i previous owner
// (ARB_ROUND_ROBIN_EN only), any_o request present, win_o owner.
// Default build: fixed dbg>cpu. ARB_ROUND_ROBIN_EN: alternate on tie.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_i,
`endif
  output logic any_o,
  output logic win_o
);

  always_comb begin
    any_o = cpu_req_i | dbg_req_i;
    win_o = dbg_req_i ? OWN_DBG : OWN_CPU;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not own the last access wins.
    if (cpu_req_i && dbg_req_i) win_o = ~last_i;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU and
// the debug/loader port, one access at a time.
// Ports: clk, rst (async, active-low); cpu_*/dbg_* request side
// (req, we, addr, wdata in; gnt, done pulses and held rdata out);
// mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in; busy out.
// Config macro: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_req;
  logic             win;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= OWN_DBG;
    else if (state_q == ST_IDLE && any_req) last_q <= win;
  end
`endif

  arb_pick u_pick (
    .cpu_req_i (cpu_req),
    .dbg_req_i (dbg_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_i    (last_q),
`endif
    .any_o     (any_req),
    .win_o     (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cnt_d       = cnt_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    cpu_done    = 1'b0;
    dbg_done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACCESS;
          owner_d = win;
          if (win == OWN_DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ST_ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        cpu_gnt = (owner_q == OWN_CPU);
        dbg_gnt = (owner_q == OWN_DBG);
        cnt_d   = CNT_W'(1);
        state_d = we_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // cnt counts cycles since mem_en; data is valid when it hits RD_LAT.
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_d = ST_DONE;
          if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata;
          else cpu_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cpu_done = (owner_q == OWN_CPU);
        dbg_done = (owner_q == OWN_DBG);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// u1 (RD_LAT=1) is the main DUT, u3 (RD_LAT=3) covers latency/reset.
module tb_mem_port_arbiter;

  localparam int L1 = 1;
  localparam int L3 = 3;
  localparam bit OWN_C = 1'b0;
  localparam bit OWN_D = 1'b1;

  typedef struct {
    bit         own;
    bit         we;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] f(input logic [4:0] a);
    if (a == 5'h03) return 8'hA5;
    return 8'(int'(a) * 29 + 11);
  endfunction

  // main DUT signals
  logic       c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [4:0] c_addr = 0, d_addr = 0;
  logic [7:0] c_wdata = 0, d_wdata = 0;
  logic       c_gnt, c_done, d_gnt, d_done;
  logic [7:0] c_rdata, d_rdata;
  logic       mem_en, mem_we, busy;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [35:0] out1;
  assign out1 = {c_gnt, c_done, c_rdata, d_gnt, d_done, d_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, busy};

  mem_port_arbiter #(.AW(5), .DW(8), .RD_LAT(L1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr),
    .cpu_wdata(c_wdata), .cpu_gnt(c_gnt), .cpu_done(c_done),
    .cpu_rdata(c_rdata),
    .dbg_req(d_req), .dbg_we(d_we), .dbg_addr(d_addr),
    .dbg_wdata(d_wdata), .dbg_gnt(d_gnt), .dbg_done(d_done),
    .dbg_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // memory model for u1: 1-cycle read pipe, junk when not read
  logic [7:0] mem [32];
  bit         mem_ld = 0;
  logic [7:0] pipe1 = 8'hEE;
  always @(posedge clk) begin
    if (!mem_ld) begin
      for (int i = 0; i < 32; i++) mem[i] <= f(5'(i));
      mem_ld <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    pipe1 <= (mem_en && !mem_we) ? mem[mem_addr] : 8'hEE;
  end
  assign mem_rdata = pipe1;

  // second DUT, RD_LAT=3, cpu port only, read-only memory
  logic       c3_req = 0, c3_we = 0, d3_req = 0, d3_we = 0;
  logic [4:0] c3_addr = 0, d3_addr = 0;
  logic [7:0] c3_wdata = 0, d3_wdata = 0;
  logic       c3_gnt, c3_done, d3_gnt, d3_done;
  logic [7:0] c3_rdata, d3_rdata;
  logic       en3, we3, busy3;
  logic [4:0] addr3;
  logic [7:0] wdata3, rdata3;
  logic [35:0] out3;
  assign out3 = {c3_gnt, c3_done, c3_rdata, d3_gnt, d3_done, d3_rdata,
                 en3, we3, addr3, wdata3, busy3};

  mem_port_arbiter #(.AW(5), .DW(8), .RD_LAT(L3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr),
    .cpu_wdata(c3_wdata), .cpu_gnt(c3_gnt), .cpu_done(c3_done),
    .cpu_rdata(c3_rdata),
    .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr),
    .dbg_wdata(d3_wdata), .dbg_gnt(d3_gnt), .dbg_done(d3_done),
    .dbg_rdata(d3_rdata),
    .mem_en(en3), .mem_we(we3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_rdata(rdata3), .busy(busy3)
  );

  logic [7:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= (en3 && !we3) ? f(addr3) : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata3 = p3[2];

  // scoreboard and reference state
  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] ref_mem [32];
  logic [7:0] exp_c_rd = 0, exp_d_rd = 0;
  bit         exp_last = OWN_D;
  int         gnt_cyc = 0, en_cnt = 0, c_gnt_n = 0, c3_done_n = 0;
  bit         en_prev = 0;

  always @(negedge clk) begin
    if (!rst) begin
      en_prev = 1'b0;
    end else begin
      if (c3_done) c3_done_n++;
      if (c_gnt | d_gnt) begin
        chk("gnt_both", c_gnt & d_gnt, 0);
        chk("gnt_en", mem_en, 1);
        gnt_cyc = cyc;
        en_cnt = 0;
      end
      if (c_gnt) c_gnt_n++;
      if (mem_en) begin
        en_cnt++;
        chk("en_b2b", en_prev, 0);
      end
      en_prev = mem_en;
      if (c_done | d_done) begin
        if (sb.size() == 0) begin
          chk("done_unexp", {c_done, d_done}, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_own", {c_done, d_done}, mon_e.own ? 2'b01 : 2'b10);
          chk("done_lat", cyc - gnt_cyc, mon_e.lat);
          chk("done_en", en_cnt, 1);
          if (!mon_e.we) begin
            if (mon_e.own) exp_d_rd = mon_e.rdata;
            else exp_c_rd = mon_e.rdata;
          end
          chk("c_rdata", c_rdata, exp_c_rd);
          chk("d_rdata", d_rdata, exp_d_rd);
        end
      end
    end
  end

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("idle_to", idle, 1);
  endtask

  task automatic do_acc(input bit own, input bit we,
                        input logic [4:0] a, input logic [7:0] wd);
    exp_t e;
    bit   seen = 0;
    e.own   = own;
    e.we    = we;
    e.lat   = we ? 1 : L1 + 1;
    e.rdata = we ? 8'h00 : ref_mem[a];
    if (we) ref_mem[a] = wd;
    sb.push_back(e);
    if (own) begin
      d_we = we; d_addr = a; d_wdata = wd; d_req = 1;
    end else begin
      c_we = we; c_addr = a; c_wdata = wd; c_req = 1;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = own ? d_gnt : c_gnt;
    end
    chk("gnt_seen", seen, 1);
    // later changes must not leak into the access
    c_req = 0; d_req = 0;
    c_addr = ~a; d_addr = ~a; c_wdata = ~wd; d_wdata = ~wd;
    exp_last = own;
    wait_idle();
  endtask

  task automatic contend();
    bit   e_own[4];
    bit   cur = exp_last;
    bit   seen;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      cur = ~cur;
      e_own[i] = cur;
`else
      e_own[i] = OWN_D;
`endif
      e.own   = e_own[i];
      e.we    = 1'b0;
      e.rdata = ref_mem[e_own[i] ? 5'd4 : 5'd2];
      e.lat   = L1 + 1;
      sb.push_back(e);
    end
    c_we = 0; c_addr = 5'd2; d_we = 0; d_addr = 5'd4;
    c_req = 1; d_req = 1;
    for (int i = 0; i < 4; i++) begin
      seen = 0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        seen = c_gnt | d_gnt;
      end
      chk("arb_gnt", seen, 1);
      chk("arb_order", d_gnt, e_own[i]);
      if (i == 3) begin
        c_req = 0; d_req = 0;
      end
    end
    exp_last = e_own[3];
    wait_idle();
  endtask

  task automatic rd3(input logic [4:0] a);
    int busy_n = 0, en_n = 0, g_c = -1, d_c = -1;
    c3_addr = a; c3_we = 0; c3_req = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (c3_gnt) begin
        g_c = cyc; c3_req = 0; c3_addr = ~a;
      end
      if (busy3) busy_n++;
      if (en3) en_n++;
      if (c3_done) d_c = cyc;
    end
    chk("l3_busy", busy_n, 5);
    chk("l3_en", en_n, 1);
    chk("l3_lat", d_c - g_c, 4);
    chk("l3_rdata", c3_rdata, f(a));
  endtask

  initial begin
    exp_t e;
    bit   seen;
    int   g0, dn0;
    for (int i = 0; i < 32; i++) ref_mem[i] = f(5'(i));
    repeat (3) @(negedge clk);
    chk("rst_out1", out1, 0);
    chk("rst_out3", out3, 0);
    rst = 1;
    @(negedge clk);

    do_acc(OWN_C, 0, 5'h03, 8'h00);
    do_acc(OWN_D, 1, 5'h1F, 8'h3C);
    do_acc(OWN_C, 0, 5'h1F, 8'h00);
    do_acc(OWN_D, 0, 5'h05, 8'h00);
    do_acc(OWN_C, 1, 5'h05, 8'h5A);
    do_acc(OWN_D, 0, 5'h05, 8'h00);
    do_acc(OWN_C, 0, 5'h03, 8'h00);

    contend();

    // cpu pulse while a dbg read is in progress
    e.own = OWN_D; e.we = 0; e.rdata = ref_mem[4]; e.lat = L1 + 1;
    sb.push_back(e);
    d_we = 0; d_addr = 5'd4; d_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = d_gnt;
    end
    chk("p6_gnt", seen, 1);
    d_req = 0;
    g0 = c_gnt_n;
    c_we = 0; c_addr = 5'd2; c_req = 1;
    @(negedge clk);
    c_req = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("p6_nognt", c_gnt_n - g0, 0);

    rd3(5'd7);

    // reset during WAIT of a u3 read
    c3_addr = 5'd9; c3_we = 0; c3_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = c3_gnt;
    end
    chk("r5_gnt", seen, 1);
    c3_req = 0;
    @(negedge clk);
    chk("r5_wait", busy3, 1);
    dn0 = c3_done_n;
    #2 rst = 0;
    #1;
    chk("r5_out3", out3, 0);
    chk("r5_out1", out1, 0);
    sb.delete();
    exp_c_rd = 0; exp_d_rd = 0; exp_last = OWN_D;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (6) @(negedge clk);
    chk("r5_nodone", c3_done_n - dn0, 0);
    rd3(5'd11);
    do_acc(OWN_C, 0, 5'h1F, 8'h00);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
